// File: rtl/decode_scoreboard_if.sv
// Decode/issue/write-back bundle between the decoder, the scoreboard and the register-file write port.
// Master drives the Decode and write-back side; slave is the scoreboard.
interface decode_scoreboard_if #(
  parameter int NUM_REGS        = 32,
  parameter int MAX_OUTSTANDING = 4
);
  localparam int RW = $clog2(NUM_REGS);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic                id_valid;
  logic [RW-1:0]       id_rs1;
  logic [RW-1:0]       id_rs2;
  logic                id_rs1_used;
  logic                id_rs2_used;
  logic [RW-1:0]       id_rd;
  logic                id_rd_we;
  logic                wb_valid;
  logic [RW-1:0]       wb_rd;
  logic                drain_req;

  logic                issue;
  logic                stall;
  logic                drain_done;
  logic [NUM_REGS-1:0] busy_vec;
  logic [CW-1:0]       outstanding;
  logic                wb_err;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_rd_we, wb_valid, wb_rd, drain_req,
    input  issue, stall, drain_done, busy_vec, outstanding, wb_err
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_rd_we, wb_valid, wb_rd, drain_req,
    output issue, stall, drain_done, busy_vec, outstanding, wb_err
  );
endinterface

// File: rtl/decode_scoreboard.sv
// Register-hazard scoreboard and issue controller for Decode, with an outstanding-write limit and drain handshake.
// Optional feature: define DECODE_SB_BYPASS_EN to let a same-cycle write-back unblock a dependent issue.
module decode_scoreboard #(
  parameter int NUM_REGS        = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              rst,
  decode_scoreboard_if.slave sb
);
  localparam int RW = $clog2(NUM_REGS);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [NUM_REGS-1:0] r_busy;
  logic [CW-1:0]       r_outstanding;
  logic                r_wbErr;
  logic                r_drainDone;

  logic [NUM_REGS-1:0] w_wbMask;
  logic [NUM_REGS-1:0] w_setMask;
  logic [NUM_REGS-1:0] w_busyEff;
  logic [NUM_REGS-1:0] w_busyNext;
  logic [CW-1:0]       w_outNext;
  logic                w_hazard;
  logic                w_full;
  logic                w_issue;
  logic                w_set;
  logic                w_wbHit;
  logic                w_wbStray;
  logic                w_rdNonZero;

  assign w_rdNonZero = (sb.id_rd != '0);
  assign w_wbHit     = sb.wb_valid & r_busy[sb.wb_rd];
  assign w_wbStray   = sb.wb_valid & (sb.wb_rd != '0) & ~r_busy[sb.wb_rd];

  always_comb begin
    w_wbMask = '0;
    if (sb.wb_valid) begin
      w_wbMask[sb.wb_rd] = 1'b1;
    end
  end

`ifdef DECODE_SB_BYPASS_EN
  // A register being written back this cycle is already safe to read or rewrite.
  assign w_busyEff = r_busy & ~w_wbMask;
`else
  assign w_busyEff = r_busy;
`endif

  assign w_hazard = (sb.id_rs1_used & w_busyEff[sb.id_rs1]) |
                    (sb.id_rs2_used & w_busyEff[sb.id_rs2]) |
                    (sb.id_rd_we    & w_busyEff[sb.id_rd]);

  assign w_full  = sb.id_rd_we & w_rdNonZero &
                   (r_outstanding == CW'(MAX_OUTSTANDING));

  assign w_issue = sb.id_valid & (r_state == RUN) & ~w_hazard & ~w_full & ~rst;
  assign w_set   = w_issue & sb.id_rd_we & w_rdNonZero;

  always_comb begin
    w_setMask = '0;
    if (w_set) begin
      w_setMask[sb.id_rd] = 1'b1;
    end
  end

  // Clear first, then set: a WAW issue in the write-back cycle keeps the register pending.
  assign w_busyNext = (r_busy & ~w_wbMask) | w_setMask;
  assign w_outNext  = r_outstanding + CW'(w_set) - CW'(w_wbHit);

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      RUN: begin
        if (sb.drain_req) begin
          w_nextState = DRAIN;
        end
      end
      DRAIN: begin
        if (!sb.drain_req) begin
          w_nextState = RUN;
        end else if (w_outNext == '0) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        if (!sb.drain_req) begin
          w_nextState = RUN;
        end
      end
      default: w_nextState = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= RUN;
      r_busy        <= '0;
      r_outstanding <= '0;
      r_wbErr       <= 1'b0;
      r_drainDone   <= 1'b0;
    end else begin
      r_state       <= w_nextState;
      r_busy        <= w_busyNext;
      r_outstanding <= w_outNext;
      r_drainDone   <= (w_nextState == DONE);
      if (w_wbStray) begin
        r_wbErr <= 1'b1;
      end
    end
  end

  assign sb.issue       = w_issue;
  assign sb.stall       = sb.id_valid & ~w_issue;
  assign sb.drain_done  = r_drainDone;
  assign sb.busy_vec    = r_busy;
  assign sb.outstanding = r_outstanding;
  assign sb.wb_err      = r_wbErr;
endmodule

// File: tb/tb_decode_scoreboard.sv
// Directed bench for decode_scoreboard: each cycle's expected outputs are queued by the stimulus
// process and checked by an independent monitor at the falling edge.
module tb_decode_scoreboard;
  typedef struct {
    string       name;
    logic        issue;
    logic        stall;
    logic [31:0] busy;
    logic [2:0]  outs;
    logic        wbErr;
    logic        drainDone;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t expQ[$];

  decode_scoreboard_if #(.NUM_REGS(32), .MAX_OUTSTANDING(4)) sbIf ();

  decode_scoreboard #(.NUM_REGS(32), .MAX_OUTSTANDING(4)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sbIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input string field,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s.%s got=%h expected=%h", name, field, act, exp);
    end
  endtask

  // One cycle: drive inputs just after the edge and queue the expected outputs for this cycle.
  task automatic applyStimulus(input string name, input logic rstIn,
                               input logic v, input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2,
                               input logic [4:0] rd, input logic we,
                               input logic wbv, input logic [4:0] wbrd, input logic drn,
                               input logic eIss, input logic eStl, input logic [31:0] eBusy,
                               input logic [2:0] eOuts, input logic eErr, input logic eDone);
    exp_t e;
    @(posedge clk);
    #1;
    rst              = rstIn;
    sbIf.id_valid    = v;
    sbIf.id_rs1      = rs1;
    sbIf.id_rs1_used = u1;
    sbIf.id_rs2      = rs2;
    sbIf.id_rs2_used = u2;
    sbIf.id_rd       = rd;
    sbIf.id_rd_we    = we;
    sbIf.wb_valid    = wbv;
    sbIf.wb_rd       = wbrd;
    sbIf.drain_req   = drn;
    e.name      = name;
    e.issue     = eIss;
    e.stall     = eStl;
    e.busy      = eBusy;
    e.outs      = eOuts;
    e.wbErr     = eErr;
    e.drainDone = eDone;
    expQ.push_back(e);
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      checkOutput(e.name, "issue",       32'(sbIf.issue),       32'(e.issue));
      checkOutput(e.name, "stall",       32'(sbIf.stall),       32'(e.stall));
      checkOutput(e.name, "busy_vec",    sbIf.busy_vec,         e.busy);
      checkOutput(e.name, "outstanding", 32'(sbIf.outstanding), 32'(e.outs));
      checkOutput(e.name, "wb_err",      32'(sbIf.wb_err),      32'(e.wbErr));
      checkOutput(e.name, "drain_done",  32'(sbIf.drain_done),  32'(e.drainDone));
    end
  end

  initial begin
    int waitCycles;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    sbIf.id_valid = 0; sbIf.id_rs1 = 0; sbIf.id_rs1_used = 0; sbIf.id_rs2 = 0;
    sbIf.id_rs2_used = 0; sbIf.id_rd = 0; sbIf.id_rd_we = 0; sbIf.wb_valid = 0;
    sbIf.wb_rd = 0; sbIf.drain_req = 0;
    repeat (2) @(posedge clk);

    //            name        rst v  rs1 u1 rs2 u2 rd we wbv wbrd drn iss stl busy          outs err done
    applyStimulus("rstHold",   1, 1, 0,  0, 0,  0, 5, 1, 0,  0,   0,  0,  1,  32'h0,        0,   0,  0);
    // RAW on r5
    applyStimulus("issR5",     0, 1, 0,  0, 0,  0, 5, 1, 0,  0,   0,  1,  0,  32'h0,        0,   0,  0);
    applyStimulus("rawStall",  0, 1, 5,  1, 0,  0, 0, 0, 0,  0,   0,  0,  1,  32'h20,       1,   0,  0);
`ifdef DECODE_SB_BYPASS_EN
    applyStimulus("rawWbCyc",  0, 1, 5,  1, 0,  0, 0, 0, 1,  5,   0,  1,  0,  32'h20,       1,   0,  0);
    applyStimulus("rawAfter",  0, 0, 0,  0, 0,  0, 0, 0, 0,  0,   0,  0,  0,  32'h0,        0,   0,  0);
`else
    applyStimulus("rawWbCyc",  0, 1, 5,  1, 0,  0, 0, 0, 1,  5,   0,  0,  1,  32'h20,       1,   0,  0);
    applyStimulus("rawAfter",  0, 1, 5,  1, 0,  0, 0, 0, 0,  0,   0,  1,  0,  32'h0,        0,   0,  0);
`endif
    // Outstanding limit
    applyStimulus("fillR1",    0, 1, 0,  0, 0,  0, 1, 1, 0,  0,   0,  1,  0,  32'h0,        0,   0,  0);
    applyStimulus("fillR2",    0, 1, 0,  0, 0,  0, 2, 1, 0,  0,   0,  1,  0,  32'h2,        1,   0,  0);
    applyStimulus("fillR3",    0, 1, 0,  0, 0,  0, 3, 1, 0,  0,   0,  1,  0,  32'h6,        2,   0,  0);
    applyStimulus("fillR4",    0, 1, 0,  0, 0,  0, 4, 1, 0,  0,   0,  1,  0,  32'hE,        3,   0,  0);
    applyStimulus("fullR6",    0, 1, 0,  0, 0,  0, 6, 1, 0,  0,   0,  0,  1,  32'h1E,       4,   0,  0);
    applyStimulus("fullWbR2",  0, 1, 0,  0, 0,  0, 6, 1, 1,  2,   0,  0,  1,  32'h1E,       4,   0,  0);
    applyStimulus("fifthIss",  0, 1, 0,  0, 0,  0, 6, 1, 0,  0,   0,  1,  0,  32'h1A,       3,   0,  0);
    applyStimulus("fullAgain", 0, 0, 0,  0, 0,  0, 0, 0, 0,  0,   0,  0,  0,  32'h5A,       4,   0,  0);
    // Reset with writes in flight and a stray write-back in the same cycle
    applyStimulus("rstMid",    1, 0, 0,  0, 0,  0, 0, 0, 1,  9,   0,  0,  0,  32'h5A,       4,   0,  0);
    applyStimulus("postRst",   0, 1, 0,  0, 0,  0, 7, 1, 0,  0,   0,  1,  0,  32'h0,        0,   0,  0);
    applyStimulus("wbR7",      0, 0, 0,  0, 0,  0, 0, 0, 1,  7,   0,  0,  0,  32'h80,       1,   0,  0);
    // Register zero never pending
    applyStimulus("r0Write1",  0, 1, 0,  1, 0,  1, 0, 1, 0,  0,   0,  1,  0,  32'h0,        0,   0,  0);
    applyStimulus("r0Write2",  0, 1, 0,  1, 0,  1, 0, 1, 0,  0,   0,  1,  0,  32'h0,        0,   0,  0);
    applyStimulus("wbR0",      0, 0, 0,  0, 0,  0, 0, 0, 1,  0,   0,  0,  0,  32'h0,        0,   0,  0);
    // Stray write-back error
    applyStimulus("wbStray9",  0, 0, 0,  0, 0,  0, 0, 0, 1,  9,   0,  0,  0,  32'h0,        0,   0,  0);
    applyStimulus("errSet",    0, 0, 0,  0, 0,  0, 0, 0, 0,  0,   0,  0,  0,  32'h0,        0,   1,  0);
    applyStimulus("errSticky", 0, 0, 0,  0, 0,  0, 0, 0, 0,  0,   0,  0,  0,  32'h0,        0,   1,  0);
    applyStimulus("errRst",    1, 0, 0,  0, 0,  0, 0, 0, 0,  0,   0,  0,  0,  32'h0,        0,   1,  0);
    // Drain with two writes in flight
    applyStimulus("drnIssR3",  0, 1, 0,  0, 0,  0, 3, 1, 0,  0,   0,  1,  0,  32'h0,        0,   0,  0);
    applyStimulus("drnIssR8",  0, 1, 0,  0, 0,  0, 8, 1, 0,  0,   0,  1,  0,  32'h8,        1,   0,  0);
    applyStimulus("drnReqRun", 0, 1, 1,  1, 0,  0, 0, 0, 0,  0,   1,  1,  0,  32'h108,      2,   0,  0);
    applyStimulus("drnWbR3",   0, 1, 1,  1, 0,  0, 0, 0, 1,  3,   1,  0,  1,  32'h108,      2,   0,  0);
    applyStimulus("drnWbR8",   0, 1, 1,  1, 0,  0, 0, 0, 1,  8,   1,  0,  1,  32'h100,      1,   0,  0);
    applyStimulus("drnDone",   0, 1, 1,  1, 0,  0, 0, 0, 0,  0,   1,  0,  1,  32'h0,        0,   0,  1);
    applyStimulus("drnDrop",   0, 1, 1,  1, 0,  0, 0, 0, 0,  0,   0,  0,  1,  32'h0,        0,   0,  1);
    applyStimulus("drnResume", 0, 1, 1,  1, 0,  0, 0, 0, 0,  0,   0,  1,  0,  32'h0,        0,   0,  0);
    // Drain with nothing in flight: DONE two cycles after the request
    applyStimulus("drn0Req",   0, 0, 0,  0, 0,  0, 0, 0, 0,  0,   1,  0,  0,  32'h0,        0,   0,  0);
    applyStimulus("drn0Drain", 0, 0, 0,  0, 0,  0, 0, 0, 0,  0,   1,  0,  0,  32'h0,        0,   0,  0);
    applyStimulus("drn0Done",  0, 0, 0,  0, 0,  0, 0, 0, 0,  0,   1,  0,  0,  32'h0,        0,   0,  1);
    applyStimulus("drn0Drop",  0, 0, 0,  0, 0,  0, 0, 0, 0,  0,   0,  0,  0,  32'h0,        0,   0,  1);
    applyStimulus("drn0Run",   0, 0, 0,  0, 0,  0, 0, 0, 0,  0,   0,  0,  0,  32'h0,        0,   0,  0);
    // Drain aborted from DRAIN, then WAW stall
    applyStimulus("abtReq",    0, 1, 0,  0, 0,  0, 12, 1, 0, 0,   1,  1,  0,  32'h0,        0,   0,  0);
    applyStimulus("abtDrain",  0, 1, 0,  0, 0,  0, 13, 1, 0, 0,   0,  0,  1,  32'h1000,     1,   0,  0);
    applyStimulus("abtRun",    0, 1, 0,  0, 0,  0, 13, 1, 0, 0,   0,  1,  0,  32'h1000,     1,   0,  0);
    applyStimulus("wawStall",  0, 1, 0,  0, 0,  0, 12, 1, 0, 0,   0,  0,  1,  32'h3000,     2,   0,  0);
    applyStimulus("idleEnd",   0, 0, 0,  0, 0,  0, 0, 0, 0,  0,   0,  0,  0,  32'h3000,     2,   0,  0);

    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 20) begin
      @(posedge clk);
      waitCycles++;
    end
    if (expQ.size() > 0) begin
      errors++;
      $display("[TB] FAIL monitorDrain pending=%0d expected=0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
